// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and constants for the clk_div_ctrl clock divider slice.
package clk_div_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun,
        StHalted,
        StStep
    } state_e;

    localparam logic [1:0] SelSlow = 2'd0;
    localparam logic [1:0] SelFast = 2'd1;
    localparam logic [1:0] SelProg = 2'd2;
    localparam logic [1:0] SelRsvd = 2'd3;

    localparam int unsigned DivSlowDefault = 2500;
    localparam int unsigned DivFastDefault = 1;

endpackage

// File: rtl/div_counter.sv
// Half-period counter: counts enabled cycles, toggles clk_out when count reaches the divisor.
module div_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    output logic [CNT_W-1:0] count,
    output logic             clk_out,
    output logic             toggle
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             clk_out_q, clk_out_d;

    always_comb begin
        toggle    = en && (count_q == div);
        count_d   = count_q;
        clk_out_d = clk_out_q;
        if (toggle) begin
            count_d   = '0;
            clk_out_d = ~clk_out_q;
        end else if (en) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            clk_out_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            clk_out_q <= clk_out_d;
        end
    end

    assign count   = count_q;
    assign clk_out = clk_out_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider with halt/single-step control and edge pulses.
// All state updates on the falling edge of clk.
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned DIV_SLOW = DivSlowDefault,
    parameter int unsigned DIV_FAST = DivFastDefault
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       sel,
    input  logic             div_wr,
    input  logic [CNT_W-1:0] div_val,
    input  logic             halt,
    input  logic             step,
    output logic             clk_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             halted
);

    localparam logic [CNT_W-1:0] DivSlowW = CNT_W'(DIV_SLOW);
    localparam logic [CNT_W-1:0] DivFastW = CNT_W'(DIV_FAST);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] prog_q, prog_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] div_next;
    logic [CNT_W-1:0] count;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             cnt_en;
    logic             toggle;
    logic             park;

    // A write landing on a toggle cycle must already feed the next phase.
    always_comb begin
        prog_d = div_wr ? div_val : prog_q;
        unique case (sel)
            SelFast:          div_next = DivFastW;
            SelProg:          div_next = prog_d;
            SelSlow, SelRsvd: div_next = DivSlowW;
        endcase
        div_d  = toggle ? div_next : div_q;
        rise_d = toggle && !clk_out;
        fall_d = toggle && clk_out;
    end

    // Park only at the very start of a high phase so the held level is always 1.
    assign park   = halt && clk_out && (count == '0);
    assign cnt_en = (state_q == StStep) || ((state_q == StRun) && !park);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (park) state_d = StHalted;
            end
            StHalted: begin
                if (!halt)     state_d = StRun;
                else if (step) state_d = StStep;
            end
            StStep: begin
                // Entered with clk_out high, so the first rising toggle ends the step.
                if (toggle && !clk_out) state_d = halt ? StHalted : StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StRun;
            prog_q  <= DivSlowW;
            div_q   <= DivSlowW;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            prog_q  <= prog_d;
            div_q   <= div_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    div_counter #(
        .CNT_W (CNT_W)
    ) u_div_counter (
        .clk     (clk),
        .reset   (reset),
        .en      (cnt_en),
        .div     (div_q),
        .count   (count),
        .clk_out (clk_out),
        .toggle  (toggle)
    );

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign halted     = (state_q == StHalted);

endmodule
